// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory_router bus port between PPU, DMA and CPU.
// Latency: grant one edge after request; bus mux and read-data path are combinational.
// Backpressure: CPU stalled via O_CPU_MEM_DISABLE while requesting without grant.
// Optional: `define ARB_STARVE_GUARD_EN enables the CPU starvation guard.

module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 160
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_PPU_REQ,
  input  logic              I_DMA_REQ,
  input  logic              I_CPU_REQ,
  input  logic [ADDR_W-1:0] I_PPU_ADDR,
  input  logic [ADDR_W-1:0] I_DMA_ADDR,
  input  logic [ADDR_W-1:0] I_CPU_ADDR,
  input  logic              I_PPU_RE_L,
  input  logic              I_DMA_RE_L,
  input  logic              I_DMA_WE_L,
  input  logic              I_CPU_RE_L,
  input  logic              I_CPU_WE_L,
  input  logic [DATA_W-1:0] I_DMA_WDATA,
  input  logic [DATA_W-1:0] I_CPU_WDATA,
  output logic              O_PPU_GNT,
  output logic              O_DMA_GNT,
  output logic              O_CPU_GNT,
  output logic              O_CPU_MEM_DISABLE,
  output logic [ADDR_W-1:0] O_BUS_ADDR,
  output logic [DATA_W-1:0] O_BUS_WDATA,
  output logic              O_BUS_RE_L,
  output logic              O_BUS_WE_L,
  input  logic [DATA_W-1:0] I_BUS_RDATA,
  output logic [DATA_W-1:0] O_RDATA
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_PPU = 2'd1,
    OWN_DMA = 2'd2,
    OWN_CPU = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  // Requests eligible for the next selection (the current owner is excluded,
  // so a releasing master can never be regranted at its own release edge).
  logic   ppu_ok;
  logic   dma_ok;
  logic   cpu_ok;
  logic   cpu_first;
  state_e sel;

  // Grants are a pure decode of the state register, hence registered and one-hot/zero.
  assign O_PPU_GNT = (state_q == OWN_PPU);
  assign O_DMA_GNT = (state_q == OWN_DMA);
  assign O_CPU_GNT = (state_q == OWN_CPU);

  assign O_CPU_MEM_DISABLE = I_CPU_REQ & ~O_CPU_GNT;

  // Read data is broadcast; only the granted requester consumes it.
  assign O_RDATA = I_BUS_RDATA;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIM8 = (STARVE_LIMIT > 255) ? 8'hFF : 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;

  // Count consecutive cycles the CPU waits for the bus; saturate at 255, clear otherwise.
  always_comb begin
    starve_cnt_d = '0;
    if (I_CPU_REQ && !O_CPU_GNT) begin
      if (starve_cnt_q == 8'hFF) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign cpu_first = (starve_cnt_q >= STARVE_LIM8);
`else
  assign cpu_first = 1'b0;
`endif

  // Select the winner among eligible requesters: PPU > DMA > CPU, unless the CPU is starved.
  always_comb begin
    ppu_ok = I_PPU_REQ & (state_q != OWN_PPU);
    dma_ok = I_DMA_REQ & (state_q != OWN_DMA);
    cpu_ok = I_CPU_REQ & (state_q != OWN_CPU);
    sel    = IDLE;
    if (cpu_first && cpu_ok) begin
      sel = OWN_CPU;
    end else if (ppu_ok) begin
      sel = OWN_PPU;
    end else if (dma_ok) begin
      sel = OWN_DMA;
    end else if (cpu_ok) begin
      sel = OWN_CPU;
    end
  end

  // Next state: the owner keeps the bus while its request is held; on release hand off directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sel;
      OWN_PPU: if (!I_PPU_REQ) state_d = sel;
      OWN_DMA: if (!I_DMA_REQ) state_d = sel;
      OWN_CPU: if (!I_CPU_REQ) state_d = sel;
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state register; reset drops any grant immediately.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus mux from the owner; reads win over simultaneous writes, the PPU can never write.
  always_comb begin
    O_BUS_ADDR  = '0;
    O_BUS_WDATA = '0;
    O_BUS_RE_L  = 1'b1;
    O_BUS_WE_L  = 1'b1;
    case (state_q)
      OWN_PPU: begin
        O_BUS_ADDR = I_PPU_ADDR;
        O_BUS_RE_L = I_PPU_RE_L;
      end
      OWN_DMA: begin
        O_BUS_ADDR  = I_DMA_ADDR;
        O_BUS_WDATA = I_DMA_WDATA;
        O_BUS_RE_L  = I_DMA_RE_L;
        O_BUS_WE_L  = I_DMA_WE_L | ~I_DMA_RE_L;
      end
      OWN_CPU: begin
        O_BUS_ADDR  = I_CPU_ADDR;
        O_BUS_WDATA = I_CPU_WDATA;
        O_BUS_RE_L  = I_CPU_RE_L;
        O_BUS_WE_L  = I_CPU_WE_L | ~I_CPU_RE_L;
      end
      default: begin
        O_BUS_ADDR  = '0;
        O_BUS_WDATA = '0;
        O_BUS_RE_L  = 1'b1;
        O_BUS_WE_L  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations,
// then randomized bursts checked every cycle against an owner-level model.
// Build with +define+ARB_STARVE_GUARD_EN to exercise the starvation guard.

module tb_mem_bus_arbiter;

  localparam int LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        ppu_req, dma_req, cpu_req;
  logic [15:0] ppu_addr, dma_addr, cpu_addr;
  logic        ppu_re_l, dma_re_l, dma_we_l, cpu_re_l, cpu_we_l;
  logic [7:0]  dma_wdata, cpu_wdata;
  logic        ppu_gnt, dma_gnt, cpu_gnt, cpu_dis;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata, rdata;
  logic        bus_re_l, bus_we_l;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // model state: 0 = idle, 1 = PPU, 2 = DMA, 3 = CPU
  int m_owner = 0;
  int m_cnt = 0;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .I_CLK(clk), .I_RESET(rst),
    .I_PPU_REQ(ppu_req), .I_DMA_REQ(dma_req), .I_CPU_REQ(cpu_req),
    .I_PPU_ADDR(ppu_addr), .I_DMA_ADDR(dma_addr), .I_CPU_ADDR(cpu_addr),
    .I_PPU_RE_L(ppu_re_l), .I_DMA_RE_L(dma_re_l), .I_DMA_WE_L(dma_we_l),
    .I_CPU_RE_L(cpu_re_l), .I_CPU_WE_L(cpu_we_l),
    .I_DMA_WDATA(dma_wdata), .I_CPU_WDATA(cpu_wdata),
    .O_PPU_GNT(ppu_gnt), .O_DMA_GNT(dma_gnt), .O_CPU_GNT(cpu_gnt),
    .O_CPU_MEM_DISABLE(cpu_dis),
    .O_BUS_ADDR(bus_addr), .O_BUS_WDATA(bus_wdata),
    .O_BUS_RE_L(bus_re_l), .O_BUS_WE_L(bus_we_l),
    .I_BUS_RDATA(bus_rdata), .O_RDATA(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs from the model owner and the present inputs.
  function automatic logic [37:0] expected();
    logic [2:0]  g;
    logic [15:0] a;
    logic [7:0]  w;
    logic        re, we, dis;
    g = 3'b000; a = 16'h0; w = 8'h0; re = 1'b1; we = 1'b1;
    if (m_owner == 1) begin
      g = 3'b100; a = ppu_addr; re = ppu_re_l;
    end else if (m_owner == 2) begin
      g = 3'b010; a = dma_addr; w = dma_wdata; re = dma_re_l; we = dma_we_l;
    end else if (m_owner == 3) begin
      g = 3'b001; a = cpu_addr; w = cpu_wdata; re = cpu_re_l; we = cpu_we_l;
    end
    if (!re && !we) we = 1'b1;
    dis = cpu_req && (m_owner != 3);
    return {g, dis, a, w, re, we, bus_rdata};
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [37:0] act, exp_v;
    if (chk_en) begin
      act   = {ppu_gnt, dma_gnt, cpu_gnt, cpu_dis, bus_addr, bus_wdata, bus_re_l, bus_we_l, rdata};
      exp_v = expected();
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got %h expected %h (owner %0d)", $time, act, exp_v, m_owner);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Model of one rising edge: the owner keeps the bus while requesting;
  // otherwise the first requester in priority order other than the old owner wins.
  task automatic model_edge();
    bit reqs[4];
    int order[3];
    int nxt;
    bit starve;
    if (rst) return;
    reqs = '{1'b0, ppu_req, dma_req, cpu_req};
    starve = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve = (m_cnt >= LIMIT);
`endif
    order = starve ? '{3, 1, 2} : '{1, 2, 3};
    if (m_owner != 0 && reqs[m_owner]) begin
      nxt = m_owner;
    end else begin
      nxt = 0;
      foreach (order[i]) begin
        if (nxt == 0 && reqs[order[i]] && order[i] != m_owner) nxt = order[i];
      end
    end
    if (cpu_req && m_owner != 3) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else m_cnt = 0;
    m_owner = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic randomize_data();
    ppu_addr  = 16'($urandom); dma_addr = 16'($urandom); cpu_addr = 16'($urandom);
    dma_wdata = 8'($urandom);  cpu_wdata = 8'($urandom); bus_rdata = 8'($urandom);
    ppu_re_l  = 1'($urandom);  dma_re_l = 1'($urandom);  dma_we_l = 1'($urandom);
    cpu_re_l  = 1'($urandom);  cpu_we_l = 1'($urandom);
  endtask

  task automatic do_reset_pulse();
    rst = 1'b1;
    m_owner = 0;
    m_cnt = 0;
    #1;
    check_lit("reset_gnt_immediate", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'd0);
    check_lit("reset_strobes_immediate", {30'd0, bus_re_l, bus_we_l}, 32'd3);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  int rem[3];
  int cpu_seen;

  initial begin
    rst = 1'b1;
    ppu_req = 0; dma_req = 0; cpu_req = 0;
    randomize_data();
    #2;
    check_lit("reset_state", {ppu_gnt, dma_gnt, cpu_gnt, bus_re_l, bus_we_l, bus_addr, bus_wdata},
              {3'b000, 1'b1, 1'b1, 16'h0, 8'h0});
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // DMA owns, then reset mid-burst, then DMA regranted after one edge.
    dma_req = 1; dma_re_l = 0;
    step();
    check_lit("dma_grant_latency", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b010);
    step();
    do_reset_pulse();
    step();
    check_lit("dma_after_reset", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b010);
    dma_req = 0;
    step();
    check_lit("idle_after_release", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b000);

    // Simultaneous requests: PPU first, DMA takes over on release with no gap.
    ppu_req = 1; dma_req = 1; cpu_req = 1;
    step();
    check_lit("prio_ppu", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b100);
    for (int i = 0; i < 3; i++) begin
      step();
      check_lit("ppu_hold", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b100);
      check_lit("cpu_stalled", {31'd0, cpu_dis}, 32'd1);
    end
    ppu_req = 0;
    step();
    check_lit("handoff_dma", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b010);
    check_lit("cpu_stalled_dma", {31'd0, cpu_dis}, 32'd1);

    // CPU write with unrelated DMA strobes active.
    dma_req = 0;
    step();
    check_lit("handoff_cpu", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b001);
    cpu_addr = 16'hC123; cpu_wdata = 8'h5A; cpu_re_l = 1; cpu_we_l = 0;
    dma_addr = 16'h1234; dma_wdata = 8'hEE; dma_re_l = 0; dma_we_l = 0;
    #1;
    check_lit("mux_addr", {16'd0, bus_addr}, 32'hC123);
    check_lit("mux_wdata", {24'd0, bus_wdata}, 32'h5A);
    check_lit("mux_strobes", {30'd0, bus_re_l, bus_we_l}, 32'b10);
    check_lit("cpu_not_stalled", {31'd0, cpu_dis}, 32'd0);

    // PPU owner can never drive a write.
    cpu_req = 0; ppu_req = 1; ppu_addr = 16'h2007; ppu_re_l = 1;
    step();
    step();
    check_lit("ppu_owner", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b100);
    check_lit("ppu_we_blocked", {31'd0, bus_we_l}, 32'd1);
    check_lit("ppu_wdata_zero", {24'd0, bus_wdata}, 32'h0);
    check_lit("ppu_addr", {16'd0, bus_addr}, 32'h2007);

    // Releasing DMA is not regranted; waiting CPU wins.
    dma_req = 1; cpu_req = 1; ppu_req = 0;
    step();
    check_lit("excl_dma_owner", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b010);
    dma_req = 0;
    step();
    check_lit("excl_cpu_wins", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b001);
    dma_req = 1;
    step();
    check_lit("excl_cpu_holds", {29'd0, ppu_gnt, dma_gnt, cpu_gnt}, 32'b001);
    dma_req = 0; cpu_req = 0;
    step();
    step();

    // Starvation scenario: DMA and PPU alternate 3-cycle bursts while CPU waits.
    cpu_seen = 0;
    cpu_req = 1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 3; c++) begin
        dma_req = (r % 2 == 0);
        ppu_req = (r % 2 == 1);
        randomize_data();
        step();
        if (cpu_gnt) cpu_seen++;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check_lit("guard_cpu_granted", {31'd0, cpu_seen > 0}, 32'd1);
`else
    check_lit("no_guard_cpu_starved", cpu_seen, 32'd0);
`endif
    ppu_req = 0; dma_req = 0; cpu_req = 0;
    step();
    step();

    // Randomized bursts; requests are held for their whole burst length.
    rem = '{0, 0, 0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] > 0) rem[k]--;
        else if ($urandom_range(3) == 0) rem[k] = $urandom_range(6, 1);
      end
      ppu_req = (rem[0] > 0);
      dma_req = (rem[1] > 0);
      cpu_req = (rem[2] > 0);
      randomize_data();
      if ($urandom_range(499) == 0) begin
        do_reset_pulse();
      end
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter that shares the single memory-router bus port between three requesters: PPU (read-only), DMA (read/write), and CPU (read/write). It sits between those masters and `memory_router`.

- Grants the port to one owner at a time.
- Drives the router's address, data and strobe inputs from that owner.
- Stalls the CPU through `O_CPU_MEM_DISABLE` while the CPU is waiting for the bus.

## Interface

Parameters:
- `ADDR_W`, 16, address width.
- `DATA_W`, 8, data width.
- `STARVE_LIMIT`, 160, number of consecutive denied CPU request cycles before the CPU is forced next in line (guard build only).

Ports:
- `I_CLK`  in  1  system clock; all state on rising edge.
- `I_RESET`  in  1  reset, asynchronous, active-high.
- `I_PPU_REQ`, `I_DMA_REQ`, `I_CPU_REQ`  in  1 each  bus request; held for the whole access burst.
- `I_PPU_ADDR`, `I_DMA_ADDR`, `I_CPU_ADDR`  in  ADDR_W each  requester address.
- `I_PPU_RE_L`  in  1  PPU read strobe, active-low.
- `I_DMA_RE_L`, `I_DMA_WE_L`, `I_CPU_RE_L`, `I_CPU_WE_L`  in  1 each  strobes, active-low.
- `I_DMA_WDATA`, `I_CPU_WDATA`  in  DATA_W each  write data.
- `O_PPU_GNT`, `O_DMA_GNT`, `O_CPU_GNT`  out  1 each  registered grant, one-hot or all zero.
- `O_CPU_MEM_DISABLE`  out  1  CPU stall; equals `I_CPU_REQ & ~O_CPU_GNT`.
- `O_BUS_ADDR`  out  ADDR_W  to router.
- `O_BUS_WDATA`  out  DATA_W  to router.
- `O_BUS_RE_L`, `O_BUS_WE_L`  out  1 each  to router.
- `I_BUS_RDATA`  in  DATA_W  read data from router.
- `O_RDATA`  out  DATA_W  `I_BUS_RDATA` passed through to all requesters; only the granted requester samples it.

## Operation

- FSM states: `IDLE`, `OWN_PPU`, `OWN_DMA`, `OWN_CPU`.
  - The grant outputs are decoded from the state register.
- In `IDLE`, at each edge, pick the highest pending request, priority PPU > DMA > CPU. No request → stay in `IDLE`.
- In `OWN_x`, stay while `I_x_REQ` is high. There is no preemption, including by the PPU.
- When the owner's REQ is sampled low:
  - Hand off at the same edge to the highest other pending request (zero dead cycles).
  - If no other request is pending, go to `IDLE`.
  - The former owner is never regranted at that same edge, even if it re-raises REQ.
- Bus mux (combinational from state):
  - Owner's address, wdata and strobes go to the `O_BUS_*` outputs.
  - `IDLE` drives `ADDR` = 0, `WDATA` = 0, `RE_L` = `WE_L` = 1.
  - Non-owner strobes are ignored.
- PPU owner: `O_BUS_WE_L` is forced to 1 and `O_BUS_WDATA` = 0.
- Both strobes low from the owner: pass `RE_L`, force `WE_L` = 1 (read wins).

## Timing

- Grant latency: REQ sampled high at edge N (bus idle) → GNT high after edge N, so the first access is in cycle N+1.
- Release: REQ sampled low at edge M → GNT low after edge M. The next owner's GNT rises after the same edge M.
- Mux latency 0; `O_RDATA` latency 0 relative to `I_BUS_RDATA`.
- `O_CPU_MEM_DISABLE` is combinational: it goes high in the same cycle the CPU raises REQ while not granted.
- Reset values, asynchronously and immediately on `I_RESET`:
  - state `IDLE`, all GNT = 0, starvation counter = 0.
  - `O_BUS_ADDR` = 0, `O_BUS_WDATA` = 0, `O_BUS_RE_L` = `O_BUS_WE_L` = 1.
- Reset mid-burst: the grant is dropped at once. After release, arbitration restarts from `IDLE` on the first edge.
- Simultaneous release and requests: resolved by the handoff rule above.

## Configuration

- Macro `ARB_STARVE_GUARD_EN`.
- Defined:
  - An 8-bit saturating counter increments each cycle that `I_CPU_REQ` = 1 and `O_CPU_GNT` = 0.
  - The counter clears on a CPU grant or when CPU REQ is low.
  - When the counter is ≥ `STARVE_LIMIT`, the next handoff or `IDLE` selection picks the CPU over PPU and DMA.
  - The current owner is still not preempted.
- Undefined: no counter; pure fixed priority PPU > DMA > CPU.

## Test plan

- Reset: assert `I_RESET` mid-cycle with the DMA owning the bus → GNTs 0 and `O_BUS_RE_L`/`WE_L` = 1 immediately. After release, DMA REQ high → `O_DMA_GNT` after 1 edge.
- Priority: PPU, DMA and CPU REQ rise together in `IDLE` → PPU granted. PPU drops after 4 cycles → DMA granted at that edge with no gap, and `O_CPU_MEM_DISABLE` = 1 throughout.
- Mux: CPU owner writes 0x5A to 0xC123 → `O_BUS_ADDR` = 0xC123, `O_BUS_WDATA` = 0x5A, `O_BUS_WE_L` = 0. Meanwhile DMA strobes low with no grant → no effect on the bus.
- PPU write block: PPU owner drives `WE_L` = 0 → `O_BUS_WE_L` stays 1.
- Handoff exclusion: DMA drops REQ and re-raises it next cycle while the CPU is requesting → CPU granted.
- Guard (`ARB_STARVE_GUARD_EN`, `STARVE_LIMIT` = 8): DMA alternates 3-cycle bursts with PPU bursts while CPU REQ is held high → CPU granted at the first handoff after 8 denied cycles. Without the macro the CPU is never granted.
